// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with runtime-loadable pattern,
// overlap control, input qualifier and saturating match counter.
module seq_detect_param #(
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b10110,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_vld,
  input  logic             pat_ld,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             match,
  output logic             match_r,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_ovf
);

  localparam int FW = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_W-2:0] hist;
  logic [FW-1:0]    fill;
  logic [PAT_W-1:0] pat;
  logic [PAT_W-1:0] win;
  logic             take;

  assign take  = in_vld & ~pat_ld;
  assign win   = {hist, in};
  assign match = take & (fill == FILL_MAX) & (win == pat);

  // A pattern load restarts the search; the coincident bit is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist    <= '0;
      fill    <= '0;
      pat     <= PATTERN;
      match_r <= 1'b0;
    end else begin
      match_r <= match;
      if (pat_ld) begin
        pat  <= pat_in;
        fill <= '0;
      end else if (in_vld) begin
        hist <= win[PAT_W-2:0];
        if (match && !OVERLAP)
          fill <= '0;
        else if (fill != FILL_MAX)
          fill <= fill + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_cnt <= '0;
      cnt_ovf   <= 1'b0;
    end else if (cnt_clr) begin
      match_cnt <= match ? CNT_W'(1) : '0;
      cnt_ovf   <= 1'b0;
    end else if (match) begin
      if (match_cnt == CNT_MAX)
        cnt_ovf <= 1'b1;
      else
        match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: three configurations
// (overlap, non-overlap, 2-bit counter) driven with directed vectors.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] in_b, vld, ld, clr;
  logic [4:0] pat_in;
  logic [2:0] m, mr, ov;
  logic [7:0] c0, c1;
  logic [1:0] c2;

  always #5 clk = ~clk;

  seq_detect_param u0 (
    .clk(clk), .rst(rst), .in(in_b[0]), .in_vld(vld[0]),
    .pat_ld(ld[0]), .pat_in(pat_in), .cnt_clr(clr[0]),
    .match(m[0]), .match_r(mr[0]), .match_cnt(c0), .cnt_ovf(ov[0])
  );

  seq_detect_param #(.OVERLAP(1'b0)) u1 (
    .clk(clk), .rst(rst), .in(in_b[1]), .in_vld(vld[1]),
    .pat_ld(ld[1]), .pat_in(pat_in), .cnt_clr(clr[1]),
    .match(m[1]), .match_r(mr[1]), .match_cnt(c1), .cnt_ovf(ov[1])
  );

  seq_detect_param #(.CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .in(in_b[2]), .in_vld(vld[2]),
    .pat_ld(ld[2]), .pat_in(pat_in), .cnt_clr(clr[2]),
    .match(m[2]), .match_r(mr[2]), .match_cnt(c2), .cnt_ovf(ov[2])
  );

  typedef struct {
    int    d;
    bit    em;
    int    er;
    int    ec;
    int    eo;
    string nm;
  } rec_t;

  rec_t q[$];
  rec_t cur;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: one record per driven cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      int am, ar, ac, ao;
      cur = q.pop_front();
      am = int'(m[cur.d]);
      ar = int'(mr[cur.d]);
      ao = int'(ov[cur.d]);
      case (cur.d)
        0: ac = int'(c0);
        1: ac = int'(c1);
        default: ac = int'(c2);
      endcase
      chk({cur.nm, ".match"}, am, int'(cur.em));
      if (cur.er >= 0) chk({cur.nm, ".match_r"}, ar, cur.er);
      if (cur.ec >= 0) chk({cur.nm, ".match_cnt"}, ac, cur.ec);
      if (cur.eo >= 0) chk({cur.nm, ".cnt_ovf"}, ao, cur.eo);
    end
  end

  task automatic step(
    input int d, input bit v, input bit b, input bit em,
    input string nm, input int er = -1, input int ec = -1,
    input int eo = -1, input bit l = 1'b0,
    input logic [4:0] p = 5'd0, input bit c = 1'b0,
    input bit a = 1'b0
  );
    rec_t r;
    @(posedge clk);
    #1;
    in_b = 3'b000;
    vld = 3'b000;
    ld = 3'b000;
    clr = 3'b000;
    in_b[d] = b;
    vld[d] = v;
    ld[d] = l;
    clr[d] = c;
    pat_in = p;
    rst = a;
    r.d = d;
    r.em = em;
    r.er = er;
    r.ec = ec;
    r.eo = eo;
    r.nm = nm;
    q.push_back(r);
  endtask

  task automatic bits(
    input int d, input logic [15:0] seq, input int n,
    input logic [15:0] ems, input string nm
  );
    for (int i = 0; i < n; i++)
      step(d, 1'b1, seq[n-1-i], ems[n-1-i], nm);
  endtask

  initial begin
    in_b = '0; vld = '0; ld = '0; clr = '0; pat_in = '0;

    step(0, 1'b1, 1'b0, 1'b0, "rst0", 0, 0, 0, 1'b0, 5'd0, 1'b0, 1'b1);
    step(1, 1'b1, 1'b0, 1'b0, "rst1", 0, 0, 0, 1'b0, 5'd0, 1'b0, 1'b1);
    step(2, 1'b1, 1'b0, 1'b0, "rst2", 0, 0, 0, 1'b0, 5'd0, 1'b0, 1'b1);

    bits(0, 16'b10110, 5, 16'b00001, "t1");
    step(0, 1'b0, 1'b0, 1'b0, "t1_idle", 1, 1);

    bits(0, 16'b110, 3, 16'b001, "t2_ov");
    step(0, 1'b0, 1'b0, 1'b0, "t2_ov_idle", 1, 2);
    bits(1, 16'b10110110, 8, 16'b00001000, "t2_nov");
    step(1, 1'b0, 1'b0, 1'b0, "t2_nov_idle", 0, 1);

    step(0, 1'b0, 1'b0, 1'b0, "t3_ld", -1, -1, -1, 1'b1, 5'b10110);
    step(0, 1'b1, 1'b1, 1'b0, "t3_b1");
    step(0, 1'b1, 1'b0, 1'b0, "t3_b2");
    step(0, 1'b0, 1'b1, 1'b0, "t3_gap");
    step(0, 1'b1, 1'b1, 1'b0, "t3_b3");
    step(0, 1'b0, 1'b0, 1'b0, "t3_gap");
    step(0, 1'b0, 1'b1, 1'b0, "t3_gap");
    step(0, 1'b1, 1'b1, 1'b0, "t3_b4");
    for (int i = 0; i < 3; i++)
      step(0, 1'b0, 1'b0, 1'b0, "t3_gap");
    step(0, 1'b1, 1'b0, 1'b1, "t3_b5");
    step(0, 1'b0, 1'b0, 1'b0, "t3_idle", 1, 3);

    bits(0, 16'b1011, 4, 16'b0000, "t4_pre");
    step(0, 1'b1, 1'b0, 1'b0, "t4_ld", -1, -1, -1, 1'b1, 5'b11111);
    bits(0, 16'b111111, 6, 16'b000011, "t4");
    step(0, 1'b0, 1'b0, 1'b0, "t4_idle", 1, 5);

    bits(2, 16'b10110110110110, 14, 16'b00001001001001, "t5");
    step(2, 1'b0, 1'b0, 1'b0, "t5_sat", 1, 3, 1);
    step(2, 1'b0, 1'b0, 1'b0, "t5_clr", -1, 3, 1, 1'b0, 5'd0, 1'b1);
    step(2, 1'b0, 1'b0, 1'b0, "t5_clred", -1, 0, 0);
    bits(2, 16'b110, 3, 16'b001, "t5_m");
    step(2, 1'b0, 1'b0, 1'b0, "t5_one", -1, 1, 0);
    step(2, 1'b1, 1'b1, 1'b0, "t5_p1");
    step(2, 1'b1, 1'b1, 1'b0, "t5_p2");
    step(2, 1'b1, 1'b0, 1'b1, "t5_clrm", -1, 1, 0, 1'b0, 5'd0, 1'b1);
    step(2, 1'b0, 1'b0, 1'b0, "t5_after", 1, 1, 0);

    bits(0, 16'b1011, 4, 16'b1000, "t6_pre");
    step(0, 1'b1, 1'b0, 1'b0, "t6_rst", 0, 0, 0, 1'b0, 5'd0, 1'b0, 1'b1);
    step(0, 1'b1, 1'b0, 1'b0, "t6_zero");
    bits(0, 16'b10110, 5, 16'b00001, "t6");
    step(0, 1'b0, 1'b0, 1'b0, "t6_idle", 1, 1);

    repeat (3) @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
